tx_mem_symbol_streamer: RTL
===========================

// Module: tx_mem_symbol_streamer
// PURPOSE
//  Avalon-MM read master that drains TX pattern words from the 1024x32 single-port TX on-chip RAM.
//  Unpacks each 32-bit word into SYM_W-bit symbols, LSB first.
//  Presents the symbols on a valid/ready stream to the serializer/channel-model stage.
//  Plays a programmed window once or loops it gaplessly; the NIOS side loads the RAM beforehand.
// PARAMETERS
//  ADDR_W   10  RAM word-address width; addresses wrap modulo 2**ADDR_W
//  DATA_W   32  RAM word width; must be a multiple of SYM_W
//  SYM_W    2   symbol width (2 = PAM4); SPW = DATA_W/SYM_W symbols per word (16)
// PORTS
//  clk             in   1       single clock, shared with the RAM
//  reset_n         in   1       asynchronous active-low reset
//  start           in   1       1-cycle pulse; accepted in IDLE only
//  stop            in   1       abort request; level or pulse
//  loop_en         in   1       sampled at start; 1 = replay the window forever
//  base_addr       in   ADDR_W  first word address, sampled at start
//  num_words       in   ADDR_W+1  window length in words (0..1024), sampled at start
//  mem_address     out  ADDR_W  RAM address
//  mem_chipselect  out  1       RAM chipselect; high only in read-issue cycles
//  mem_write       out  1       tied 0
//  mem_clken       out  1       tied 1
//  mem_readdata    in   DATA_W  RAM q; valid the cycle after the address/chipselect cycle
//  sym_data        out  SYM_W   current symbol
//  sym_valid       out  1       symbol valid
//  sym_ready       in   1       downstream accepts when valid&ready
//  busy            out  1       high in any state other than IDLE
//  done            out  1       1-cycle pulse when a non-loop window completes
// BEHAVIOUR
//  Reset: all outputs 0, mem_clken=1. State=IDLE; buffers empty; counters 0.
//  FSM states:
//   IDLE: start -> FILL (or DONE if num_words==0).
//   FILL: first word in flight.
//   STREAM: symbols being emitted.
//   DRAIN: last word's symbols remain and no further reads are issued.
//   DONE: pulse done, then -> IDLE.
//  Latency: start high in cycle 0 -> read of base_addr issued cycle 1 -> word captured at end of cycle 2.
//   sym_valid rises in cycle 3.
//  Buffering: cur_word (shifting, SPW symbols) plus one prefetch word nxt_word with nxt_full.
//   A read issues when nxt_full=0, no read is outstanding, and words remain (or loop_en).
//   At most one read is outstanding.
//  Throughput: with sym_ready held high, one symbol per cycle and no bubble at word boundaries.
//   This includes the loop wrap from the last word back to base_addr.
//  Handshake: once sym_valid=1, sym_data holds stable until valid&ready.
//   Shift occurs only on valid&ready. After the SPWth symbol of a word, nxt_word loads the same cycle.
//  Addressing: rd_addr = base_addr + word_idx, truncated to ADDR_W (0x3FF+1 -> 0x000).
//   word_idx counts 0..num_words-1. In loop mode it restarts at 0 with no idle cycle.
//  Termination (non-loop): the last symbol of the last word is accepted -> DONE (done=1 one cycle) -> IDLE.
//  stop: if sym_valid && !sym_ready, the current symbol is held until accepted. Then:
//   sym_valid drops, buffers flush, any outstanding readdata is discarded, state -> IDLE.
//   No done pulse on stop. stop while IDLE: no effect.
//  start while busy: ignored. start and stop in the same IDLE cycle: stop wins; no read is issued.
//  Asynchronous reset mid-window: immediate return to reset values; no done pulse.
// STRUCTURE
//  Shared package tx_stream_pkg holds:
//   state enum (IDLE, FILL, STREAM, DRAIN, DONE)
//   SPW localparam function
//   symbol-index width $clog2(SPW)
//  One sub-module: tx_sym_unpacker.
//   Holds cur_word/nxt_word and the symbol index; drives sym_data/sym_valid.
//   Requests a refill. Its ports are load/word_in/ready/empty.
//  The parent holds the FSM, address counter, read-issue and outstanding-read tracking.
// TESTING
//  1. RAM[0]=0xE4E4E4E4; base=0, num_words=1, loop=0, ready=1.
//     -> symbols 0,1,2,3 repeated 4x (16 total); first valid in cycle 3; done pulses once; 1 chipselect.
//  2. base=0x3FE, num_words=4, RAM[i]=i.
//     -> reads 0x3FE,0x3FF,0x000,0x001; 64 symbols, no bubbles; done after symbol 64.
//  3. loop=1, num_words=2, RAM[0]=0x0, RAM[1]=0xFFFFFFFF, ready=1 for 100 cycles.
//     -> 16x0,16x3 pattern repeats with no gap at the wrap; busy stays 1; done never pulses.
//  4. ready toggled by random 30% backpressure.
//     -> sym_data stable while valid&!ready; symbol order matches the RAM contents exactly.
//  5. stop asserted at symbol 5 of a 4-word window, with ready=0 on that cycle.
//     -> symbol 5 is held until accepted, then valid=0, busy=0, no done; a new start works cleanly.
//  6. num_words=0 -> done in the cycle after start, no chipselect.
//     reset_n low mid-stream -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/tx_stream_pkg.sv
// Shared types and helpers for the TX RAM symbol streamer.
package tx_stream_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } tx_state_e;

  function automatic int spw_of(input int data_w, input int sym_w);
    return data_w / sym_w;
  endfunction

  function automatic int sym_idx_w(input int spw);
    return (spw > 1) ? $clog2(spw) : 1;
  endfunction

endpackage

// File: rtl/tx_sym_unpacker.sv
// Two-word symbol buffer: shifts cur_word out LSB first and keeps one prefetched word.
module tx_sym_unpacker
  import tx_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SYM_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  input  logic              ready,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_valid,
  output logic              empty,
  output logic              word_end
);

  localparam int SPW   = spw_of(DATA_W, SYM_W);
  localparam int IDX_W = sym_idx_w(SPW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPW - 1);

  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] nxt_word;
  logic              cur_valid;
  logic              nxt_full;
  logic [IDX_W-1:0]  sym_idx;
  logic              fire;

  assign fire      = cur_valid & ready;
  assign word_end  = fire && (sym_idx == LAST_IDX);
  assign sym_data  = cur_word[SYM_W-1:0];
  assign sym_valid = cur_valid;
  assign empty     = ~nxt_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_word  <= '0;
      nxt_word  <= '0;
      cur_valid <= 1'b0;
      nxt_full  <= 1'b0;
      sym_idx   <= '0;
    end else if (flush) begin
      cur_word  <= '0;
      nxt_word  <= '0;
      cur_valid <= 1'b0;
      nxt_full  <= 1'b0;
      sym_idx   <= '0;
    end else if (word_end) begin
      // Word boundary: promote the prefetch (or the arriving word) with no bubble.
      sym_idx <= '0;
      if (nxt_full) begin
        cur_word <= nxt_word;
        nxt_full <= load;
        if (load) nxt_word <= word_in;
      end else if (load) begin
        cur_word <= word_in;
      end else begin
        cur_word  <= '0;
        cur_valid <= 1'b0;
      end
    end else begin
      if (fire) begin
        cur_word <= cur_word >> SYM_W;
        sym_idx  <= sym_idx + 1'b1;
      end
      if (load) begin
        if (!cur_valid) begin
          cur_word  <= word_in;
          cur_valid <= 1'b1;
        end else begin
          nxt_word <= word_in;
          nxt_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tx_mem_symbol_streamer.sv
// Avalon-MM read master draining a TX pattern window from RAM into a symbol stream.
//  state  | meaning
//  IDLE   | waiting for start
//  FILL   | first word in flight
//  STREAM | symbols emitted, reads still to issue
//  DRAIN  | no further reads; remaining symbols emitted
//  DONE   | done pulse, then IDLE
module tx_mem_symbol_streamer
  import tx_stream_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int SYM_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              busy,
  output logic              done
);

  tx_state_e         state;
  logic              loop_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   num_q;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   idx_inc;
  logic              rvalid;
  logic              stop_pend;
  logic              unp_empty;
  logic              word_end;
  logic              active;
  logic              stop_req;
  logic              flush_now;
  logic              more;
  logic              issue;
  logic              finish;

  assign mem_write = 1'b0;
  assign mem_clken = 1'b1;

  assign active    = (state == FILL) || (state == STREAM) || (state == DRAIN);
  assign stop_req  = active && (stop || stop_pend);
  // A symbol stalled by backpressure must be accepted before the flush.
  assign flush_now = stop_req && !(sym_valid && !sym_ready);
  assign more      = loop_q || (word_idx != num_q);
  assign issue     = active && !stop_req && unp_empty && !mem_chipselect && !rvalid && more;
  assign finish    = active && !more && !mem_chipselect && !rvalid && unp_empty && word_end;

  always_comb begin
    idx_inc = word_idx + 1'b1;
    if (loop_q && (idx_inc == num_q)) idx_inc = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      loop_q         <= 1'b0;
      base_q         <= '0;
      num_q          <= '0;
      word_idx       <= '0;
      rvalid         <= 1'b0;
      stop_pend      <= 1'b0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      rvalid         <= mem_chipselect && !flush_now;
      mem_chipselect <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (start && !stop) begin
            loop_q <= loop_en;
            base_q <= base_addr;
            num_q  <= num_words;
            busy   <= 1'b1;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state          <= FILL;
              mem_chipselect <= 1'b1;
              mem_address    <= base_addr;
              word_idx       <= (loop_en && (num_words == (ADDR_W+1)'(1))) ? '0 : (ADDR_W+1)'(1);
            end
          end
        end
        FILL, STREAM, DRAIN: begin
          if (flush_now) begin
            state     <= IDLE;
            busy      <= 1'b0;
            stop_pend <= 1'b0;
            word_idx  <= '0;
          end else if (finish) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            if (stop) stop_pend <= 1'b1;
            if (issue) begin
              mem_chipselect <= 1'b1;
              mem_address    <= base_q + word_idx[ADDR_W-1:0];
              word_idx       <= idx_inc;
            end
            if (state == FILL) begin
              if (rvalid) state <= more ? STREAM : DRAIN;
            end else if (state == STREAM && !more) begin
              state <= DRAIN;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  tx_sym_unpacker #(
    .DATA_W (DATA_W),
    .SYM_W  (SYM_W)
  ) u_unpacker (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush_now),
    .load      (rvalid),
    .word_in   (mem_readdata),
    .ready     (sym_ready),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .empty     (unp_empty),
    .word_end  (word_end)
  );

endmodule
